// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline stages and the hazard controller: DEC/EXE/MEM payloads in,
// per-stage stall/bubble/flush controls, FSM state and perf counters out.
interface hazard_ctrl_if #(
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int CSR_CTRL_WIDTH = 2,
  parameter int PERF_WIDTH     = 32
);
  logic                      dec_valid;
  logic [RF_ADDR_WIDTH-1:0]  dec_rs1;
  logic [RF_ADDR_WIDTH-1:0]  dec_rs2;
  logic                      dec_rs1_used;
  logic                      dec_rs2_used;
  logic [CSR_ADDR_WIDTH-1:0] dec_csr_raddr;
  logic                      dec_csr_read;

  logic                      exe_valid;
  logic [RF_ADDR_WIDTH-1:0]  exe_rd;
  logic [CSR_ADDR_WIDTH-1:0] exe_csr_waddr;
  logic [CSR_CTRL_WIDTH-1:0] exe_csr_ctrl;
  logic                      exe_redirect;

  logic                      mem_valid;
  logic [RF_ADDR_WIDTH-1:0]  mem_rd;
  logic [CSR_ADDR_WIDTH-1:0] mem_csr_waddr;
  logic [CSR_CTRL_WIDTH-1:0] mem_csr_ctrl;
  logic                      mem_busy;

  logic                      if_stall;
  logic                      dec_stall;
  logic                      exe_stall;
  logic                      exe_bubble;
  logic                      if_flush;
  logic                      dec_flush;
  logic [1:0]                state_o;
  logic [PERF_WIDTH-1:0]     perf_raw;
  logic [PERF_WIDTH-1:0]     perf_mem;
  logic [PERF_WIDTH-1:0]     perf_flush;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_csr_raddr, dec_csr_read,
    output exe_valid, exe_rd, exe_csr_waddr, exe_csr_ctrl, exe_redirect,
    output mem_valid, mem_rd, mem_csr_waddr, mem_csr_ctrl, mem_busy,
    input  if_stall, dec_stall, exe_stall, exe_bubble, if_flush, dec_flush,
    input  state_o, perf_raw, perf_mem, perf_flush
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, dec_csr_raddr, dec_csr_read,
    input  exe_valid, exe_rd, exe_csr_waddr, exe_csr_ctrl, exe_redirect,
    input  mem_valid, mem_rd, mem_csr_waddr, mem_csr_ctrl, mem_busy,
    output if_stall, dec_stall, exe_stall, exe_bubble, if_flush, dec_flush,
    output state_o, perf_raw, perf_mem, perf_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline controller: RAW detection against EXE/MEM, multi-cycle flush after redirects,
// freeze on data-memory busy, and saturating performance counters.
module hazard_ctrl #(
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int CSR_CTRL_WIDTH = 2,
  parameter int FLUSH_CYCLES   = 2,
  parameter int PERF_WIDTH     = 32
) (
  input logic           clk,
  input logic           rstn,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FLUSH  = 2'b01,
    ST_FREEZE = 2'b10,
    ST_BAD    = 2'b11
  } state_e;

  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [PERF_WIDTH-1:0] perfRaw_q, perfRaw_d;
  logic [PERF_WIDTH-1:0] perfMem_q, perfMem_d;
  logic [PERF_WIDTH-1:0] perfFlush_q, perfFlush_d;
  logic                  incRaw, incMem, incFlush;
  logic                  gprHaz, csrHaz, rawHaz;

  // x0 is hard-wired zero, so a source or destination of 0 never forms a dependency
  function automatic logic gprMatch(input logic used, input logic [RF_ADDR_WIDTH-1:0] rs,
                                    input logic vld, input logic [RF_ADDR_WIDTH-1:0] rd);
    return used && (rs != '0) && vld && (rd == rs);
  endfunction

  function automatic logic csrMatch(input logic vld, input logic [CSR_CTRL_WIDTH-1:0] ctrl,
                                    input logic [CSR_ADDR_WIDTH-1:0] waddr,
                                    input logic [CSR_ADDR_WIDTH-1:0] raddr);
    return vld && (ctrl != '0) && (waddr == raddr);
  endfunction

  function automatic logic [PERF_WIDTH-1:0] satInc(input logic inc, input logic [PERF_WIDTH-1:0] val);
    return (inc && (val != '1)) ? val + PERF_WIDTH'(1) : val;
  endfunction

  always_comb begin
    gprHaz = bus.dec_valid &&
             (gprMatch(bus.dec_rs1_used, bus.dec_rs1, bus.exe_valid, bus.exe_rd) ||
              gprMatch(bus.dec_rs1_used, bus.dec_rs1, bus.mem_valid, bus.mem_rd) ||
              gprMatch(bus.dec_rs2_used, bus.dec_rs2, bus.exe_valid, bus.exe_rd) ||
              gprMatch(bus.dec_rs2_used, bus.dec_rs2, bus.mem_valid, bus.mem_rd));
    csrHaz = bus.dec_valid && bus.dec_csr_read &&
             (csrMatch(bus.exe_valid, bus.exe_csr_ctrl, bus.exe_csr_waddr, bus.dec_csr_raddr) ||
              csrMatch(bus.mem_valid, bus.mem_csr_ctrl, bus.mem_csr_waddr, bus.dec_csr_raddr));
    rawHaz = gprHaz || csrHaz;
  end

  always_comb begin
    bus.if_stall   = 1'b0;
    bus.dec_stall  = 1'b0;
    bus.exe_stall  = 1'b0;
    bus.exe_bubble = 1'b0;
    bus.if_flush   = 1'b0;
    bus.dec_flush  = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    incRaw         = 1'b0;
    incMem         = 1'b0;
    incFlush       = 1'b0;

    if (!rstn) begin
      bus.if_flush  = 1'b1;
      bus.dec_flush = 1'b1;
      state_d       = ST_RUN;
      cnt_d         = '0;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          bus.if_flush   = 1'b1;
          bus.dec_flush  = 1'b1;
          bus.exe_bubble = 1'b1;
          if (bus.mem_busy) begin
            bus.exe_stall = 1'b1;
            incMem        = 1'b1;
          end else if (bus.exe_redirect) begin
            cnt_d    = CNT_RELOAD;
            incFlush = 1'b1;
            if (FLUSH_CYCLES <= 1) state_d = ST_RUN;
          end else if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        // FREEZE and the unreachable encoding share RUN's decision so that leaving
        // the freeze costs no dead cycle and a corrupted state falls back to RUN
        default: begin
          if (bus.mem_busy) begin
            bus.if_stall  = 1'b1;
            bus.dec_stall = 1'b1;
            bus.exe_stall = 1'b1;
            incMem        = 1'b1;
            state_d       = ST_FREEZE;
          end else if (bus.exe_redirect) begin
            bus.if_flush   = 1'b1;
            bus.dec_flush  = 1'b1;
            bus.exe_bubble = 1'b1;
            incFlush       = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_RELOAD;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
            if (rawHaz) begin
              bus.if_stall   = 1'b1;
              bus.dec_stall  = 1'b1;
              bus.exe_bubble = 1'b1;
              incRaw         = 1'b1;
            end
          end
        end
      endcase
    end

    perfRaw_d   = satInc(incRaw, perfRaw_q);
    perfMem_d   = satInc(incMem, perfMem_q);
    perfFlush_d = satInc(incFlush, perfFlush_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      perfRaw_q   <= '0;
      perfMem_q   <= '0;
      perfFlush_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      perfRaw_q   <= perfRaw_d;
      perfMem_q   <= perfMem_d;
      perfFlush_q <= perfFlush_d;
    end
  end

  assign bus.state_o    = state_q;
  assign bus.perf_raw   = perfRaw_q;
  assign bus.perf_mem   = perfMem_q;
  assign bus.perf_flush = perfFlush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand-built multi-cycle sequences,
// with a narrow-counter second instance used to reach counter saturation.
module tb_hazard_ctrl;
  localparam int RFW = 5;
  localparam int CAW = 12;
  localparam int CCW = 2;
  localparam int PW  = 32;

  localparam logic [5:0] CTL_IDLE   = 6'b000000;
  localparam logic [5:0] CTL_STALL  = 6'b110100;
  localparam logic [5:0] CTL_FREEZE = 6'b111000;
  localparam logic [5:0] CTL_FLUSH  = 6'b000111;
  localparam logic [5:0] CTL_FLBUSY = 6'b001111;
  localparam logic [5:0] CTL_RESET  = 6'b000011;
  localparam logic [1:0] S_RUN      = 2'b00;
  localparam logic [1:0] S_FLUSH    = 2'b01;
  localparam logic [1:0] S_FREEZE   = 2'b10;

  typedef struct {
    string      name;
    logic       rstn;
    logic       decValid;
    logic [4:0] rs1, rs2;
    logic       rs1Used, rs2Used;
    logic [11:0] csrRaddr;
    logic       csrRead;
    logic       exeValid;
    logic [4:0] exeRd;
    logic [11:0] exeCsrWaddr;
    logic [1:0] exeCsrCtrl;
    logic       exeRedirect;
    logic       memValid;
    logic [4:0] memRd;
    logic [11:0] memCsrWaddr;
    logic [1:0] memCsrCtrl;
    logic       memBusy;
    logic [5:0] expCtl;
    logic [1:0] expState;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] ctl;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.RF_ADDR_WIDTH(RFW), .CSR_ADDR_WIDTH(CAW), .CSR_CTRL_WIDTH(CCW), .PERF_WIDTH(PW)) busIf();
  hazard_ctrl_if #(.RF_ADDR_WIDTH(RFW), .CSR_ADDR_WIDTH(CAW), .CSR_CTRL_WIDTH(CCW), .PERF_WIDTH(4)) smallIf();

  hazard_ctrl #(.RF_ADDR_WIDTH(RFW), .CSR_ADDR_WIDTH(CAW), .CSR_CTRL_WIDTH(CCW),
                .FLUSH_CYCLES(2), .PERF_WIDTH(PW)) dut (.clk(clk), .rstn(rstn), .bus(busIf.slave));
  hazard_ctrl #(.RF_ADDR_WIDTH(RFW), .CSR_ADDR_WIDTH(CAW), .CSR_CTRL_WIDTH(CCW),
                .FLUSH_CYCLES(2), .PERF_WIDTH(4)) dutSmall (.clk(clk), .rstn(rstn), .bus(smallIf.slave));

  assign smallIf.dec_valid     = busIf.dec_valid;
  assign smallIf.dec_rs1       = busIf.dec_rs1;
  assign smallIf.dec_rs2       = busIf.dec_rs2;
  assign smallIf.dec_rs1_used  = busIf.dec_rs1_used;
  assign smallIf.dec_rs2_used  = busIf.dec_rs2_used;
  assign smallIf.dec_csr_raddr = busIf.dec_csr_raddr;
  assign smallIf.dec_csr_read  = busIf.dec_csr_read;
  assign smallIf.exe_valid     = busIf.exe_valid;
  assign smallIf.exe_rd        = busIf.exe_rd;
  assign smallIf.exe_csr_waddr = busIf.exe_csr_waddr;
  assign smallIf.exe_csr_ctrl  = busIf.exe_csr_ctrl;
  assign smallIf.exe_redirect  = busIf.exe_redirect;
  assign smallIf.mem_valid     = busIf.mem_valid;
  assign smallIf.mem_rd        = busIf.mem_rd;
  assign smallIf.mem_csr_waddr = busIf.mem_csr_waddr;
  assign smallIf.mem_csr_ctrl  = busIf.mem_csr_ctrl;
  assign smallIf.mem_busy      = busIf.mem_busy;

  function automatic vec_t idleVec(input string name);
    vec_t v;
    v.name = name;          v.rstn = 1'b1;
    v.decValid = 1'b0;      v.rs1 = '0;          v.rs2 = '0;
    v.rs1Used = 1'b0;       v.rs2Used = 1'b0;    v.csrRaddr = '0;   v.csrRead = 1'b0;
    v.exeValid = 1'b0;      v.exeRd = '0;        v.exeCsrWaddr = '0;
    v.exeCsrCtrl = '0;      v.exeRedirect = 1'b0;
    v.memValid = 1'b0;      v.memRd = '0;        v.memCsrWaddr = '0;
    v.memCsrCtrl = '0;      v.memBusy = 1'b0;
    v.expCtl = CTL_IDLE;    v.expState = S_RUN;
    return v;
  endfunction

  // EXE writes x5 while DEC reads x5 through rs1
  function automatic vec_t rawVec(input string name);
    vec_t v = idleVec(name);
    v.decValid = 1'b1; v.rs1 = 5'd5; v.rs1Used = 1'b1;
    v.exeValid = 1'b1; v.exeRd = 5'd5;
    v.expCtl = CTL_STALL;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rstn                 = v.rstn;
    busIf.dec_valid      = v.decValid;
    busIf.dec_rs1        = v.rs1;
    busIf.dec_rs2        = v.rs2;
    busIf.dec_rs1_used   = v.rs1Used;
    busIf.dec_rs2_used   = v.rs2Used;
    busIf.dec_csr_raddr  = v.csrRaddr;
    busIf.dec_csr_read   = v.csrRead;
    busIf.exe_valid      = v.exeValid;
    busIf.exe_rd         = v.exeRd;
    busIf.exe_csr_waddr  = v.exeCsrWaddr;
    busIf.exe_csr_ctrl   = v.exeCsrCtrl;
    busIf.exe_redirect   = v.exeRedirect;
    busIf.mem_valid      = v.memValid;
    busIf.mem_rd         = v.memRd;
    busIf.mem_csr_waddr  = v.memCsrWaddr;
    busIf.mem_csr_ctrl   = v.memCsrCtrl;
    busIf.mem_busy       = v.memBusy;
    e.name = v.name; e.ctl = v.expCtl; e.st = v.expState;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] act;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: no expected entry queued");
    end else begin
      e   = expQ.pop_front();
      act = {busIf.if_stall, busIf.dec_stall, busIf.exe_stall,
             busIf.exe_bubble, busIf.if_flush, busIf.dec_flush};
      if (act !== e.ctl) begin
        errors++;
        $display("[TB] FAIL %s ctl actual=%b required=%b", e.name, act, e.ctl);
      end
      checks++;
      if (busIf.state_o !== e.st) begin
        errors++;
        $display("[TB] FAIL %s state actual=%b required=%b", e.name, busIf.state_o, e.st);
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic checkPerf(input string tag, input int r, input int m, input int f);
    checkVal({tag, " perf_raw"},   busIf.perf_raw,   r);
    checkVal({tag, " perf_mem"},   busIf.perf_mem,   m);
    checkVal({tag, " perf_flush"}, busIf.perf_flush, f);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    // bring the state register out of X before any checked cycle
    v = idleVec("pre_reset"); v.rstn = 1'b0;
    applyStimulus(v);
    void'(expQ.pop_back());
    @(posedge clk);
    #1;

    v = rawVec("reset_override"); v.rstn = 1'b0; v.memBusy = 1'b1; v.exeRedirect = 1'b1;
    v.expCtl = CTL_RESET;
    runVec(v);
    checkPerf("after_reset", 0, 0, 0);

    tbl.push_back(rawVec("gpr_exe_rs1"));
    v = idleVec("x0_no_match"); v.decValid = 1'b1; v.rs1Used = 1'b1; v.exeValid = 1'b1;
    tbl.push_back(v);
    v = rawVec("rs1_unused"); v.rs1Used = 1'b0; v.expCtl = CTL_IDLE; tbl.push_back(v);
    v = rawVec("exe_invalid"); v.exeValid = 1'b0; v.expCtl = CTL_IDLE; tbl.push_back(v);
    v = idleVec("gpr_mem_rs2"); v.decValid = 1'b1; v.rs2 = 5'd7; v.rs2Used = 1'b1;
    v.memValid = 1'b1; v.memRd = 5'd7; v.expCtl = CTL_STALL; tbl.push_back(v);
    v = rawVec("dec_invalid"); v.decValid = 1'b0; v.expCtl = CTL_IDLE; tbl.push_back(v);
    v = idleVec("csr_mem_300"); v.decValid = 1'b1; v.csrRead = 1'b1; v.csrRaddr = 12'h300;
    v.memValid = 1'b1; v.memCsrCtrl = 2'd1; v.memCsrWaddr = 12'h300; v.expCtl = CTL_STALL;
    tbl.push_back(v);
    v.name = "csr_addr_305"; v.csrRaddr = 12'h305; v.expCtl = CTL_IDLE; tbl.push_back(v);
    v.name = "csr_ctrl_zero"; v.csrRaddr = 12'h300; v.memCsrCtrl = 2'd0; tbl.push_back(v);
    v = idleVec("csr_exe_noread"); v.decValid = 1'b1; v.csrRaddr = 12'h341;
    v.exeValid = 1'b1; v.exeCsrCtrl = 2'd2; v.exeCsrWaddr = 12'h341; tbl.push_back(v);
    v.name = "csr_exe_read"; v.csrRead = 1'b1; v.expCtl = CTL_STALL; tbl.push_back(v);
    v = rawVec("raw_and_busy"); v.memBusy = 1'b1; v.expCtl = CTL_FREEZE; tbl.push_back(v);
    v = rawVec("busy_drop_raw"); v.expState = S_FREEZE; tbl.push_back(v);
    v = idleVec("busy_run"); v.memBusy = 1'b1; v.expCtl = CTL_FREEZE; tbl.push_back(v);
    v.name = "busy_freeze"; v.expState = S_FREEZE; tbl.push_back(v);
    v = idleVec("freeze_exit"); v.expState = S_FREEZE; tbl.push_back(v);

    foreach (tbl[i]) runVec(tbl[i]);
    checkPerf("table", 5, 3, 0);

    // redirect with a RAW hazard present: flush wins for two cycles, then the stall returns
    v = rawVec("redir_raw"); v.exeRedirect = 1'b1; v.expCtl = CTL_FLUSH; runVec(v);
    v = rawVec("redir_flush2"); v.expCtl = CTL_FLUSH; v.expState = S_FLUSH; runVec(v);
    v = rawVec("redir_back_run"); runVec(v);
    runVec(idleVec("redir_idle"));
    checkPerf("redirect", 6, 3, 1);

    v = idleVec("busy_flush_start"); v.exeRedirect = 1'b1; v.expCtl = CTL_FLUSH; runVec(v);
    for (int i = 0; i < 3; i++) begin
      v = idleVec("busy_in_flush"); v.memBusy = 1'b1; v.expCtl = CTL_FLBUSY; v.expState = S_FLUSH;
      runVec(v);
    end
    v = idleVec("flush_last"); v.expCtl = CTL_FLUSH; v.expState = S_FLUSH; runVec(v);
    runVec(idleVec("flush_done"));
    checkPerf("busy_flush", 6, 6, 2);

    v = idleVec("reload_a"); v.exeRedirect = 1'b1; v.expCtl = CTL_FLUSH; runVec(v);
    v.name = "reload_b"; v.expState = S_FLUSH; runVec(v);
    v = idleVec("reload_c"); v.expCtl = CTL_FLUSH; v.expState = S_FLUSH; runVec(v);
    runVec(idleVec("reload_done"));
    checkPerf("reload", 6, 6, 4);

    v = idleVec("rst_flush_a"); v.exeRedirect = 1'b1; v.expCtl = CTL_FLUSH; runVec(v);
    v = idleVec("rst_mid_flush"); v.rstn = 1'b0; v.expCtl = CTL_RESET; v.expState = S_FLUSH;
    runVec(v);
    runVec(idleVec("rst_after"));
    checkPerf("mid_reset", 0, 0, 0);

    for (int i = 0; i < 20; i++) runVec(rawVec("sat_raw"));
    checkVal("wide perf_raw", busIf.perf_raw, 32'd20);
    checkVal("narrow perf_raw saturated", 32'(smallIf.perf_raw), 32'd15);
    checkVal("narrow perf_mem", 32'(smallIf.perf_mem), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
